// File: rtl/data_reg_reader.sv
// ----------------------------------------------------------------------------
// data_reg_reader
//
// Read-side companion to the 4-unit data register bank. On a request it takes
// a snapshot of the bank's four outputs and streams the words, one per beat,
// over a valid/ready interface. Each beat carries the word's unit address.
// A full scan sends units 0..LAST_ADDR. A single addressed read sends one word.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in0..in3     bank outputs for units 0..3
//   readAll      request a full scan (0..LAST_ADDR)
//   readAddress  request a single word at 'address'; wins over readAll
//   address      unit selected for readAddress
//   outReady     downstream accepts the current beat
//   dataOut      current word
//   outAddress   unit index of dataOut
//   outValid     beat valid
//   outLast      marks the final beat of a transfer
//   busy         high while sending and during the done cycle
//   done         one-cycle pulse after the final beat is accepted
// ----------------------------------------------------------------------------
module data_reg_reader #(
    parameter int WIDTH     = 32,
    parameter int LAST_ADDR = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             readAll,
    input  logic             readAddress,
    input  logic [1:0]       address,
    input  logic             outReady,
    output logic [WIDTH-1:0] dataOut,
    output logic [1:0]       outAddress,
    output logic             outValid,
    output logic             outLast,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [1:0] SCAN_END = 2'(LAST_ADDR);

    state_t           state, state_next;
    logic [WIDTH-1:0] snap [4];
    logic [WIDTH-1:0] snap_next [4];
    logic [WIDTH-1:0] in_words [4];
    logic [1:0]       cur, cur_next;
    logic [1:0]       end_addr, end_next;
    logic [1:0]       cur_inc;
    logic [WIDTH-1:0] data_next;
    logic [1:0]       addr_next;
    logic             valid_next, last_next, busy_next, done_next;

    assign in_words[0] = in0;
    assign in_words[1] = in1;
    assign in_words[2] = in2;
    assign in_words[3] = in3;
    assign cur_inc     = cur + 2'd1;

    // State and registered outputs. Every output is loaded from its
    // precomputed next value, so the first beat is already on the bus in the
    // cycle right after the request edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            end_addr   <= '0;
            dataOut    <= '0;
            outAddress <= '0;
            outValid   <= 1'b0;
            outLast    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap[i] <= '0;
            end
        end else begin
            state      <= state_next;
            cur        <= cur_next;
            end_addr   <= end_next;
            dataOut    <= data_next;
            outAddress <= addr_next;
            outValid   <= valid_next;
            outLast    <= last_next;
            busy       <= busy_next;
            done       <= done_next;
            snap       <= snap_next;
        end
    end

    // Next-state and next-output logic. In IDLE the word for the first beat
    // comes straight from the bank inputs, because the snapshot is loaded on
    // the same edge. Later beats read the snapshot, so changes on the inputs
    // after the request edge never reach queued words.
    always_comb begin
        state_next = state;
        snap_next  = snap;
        cur_next   = cur;
        end_next   = end_addr;
        data_next  = dataOut;
        addr_next  = outAddress;
        valid_next = outValid;
        last_next  = outLast;
        busy_next  = busy;
        done_next  = 1'b0;

        unique case (state)
            IDLE: begin
                valid_next = 1'b0;
                last_next  = 1'b0;
                busy_next  = 1'b0;
                if (readAddress) begin
                    snap_next  = in_words;
                    cur_next   = address;
                    end_next   = address;
                    data_next  = in_words[address];
                    addr_next  = address;
                    valid_next = 1'b1;
                    last_next  = 1'b1;
                    busy_next  = 1'b1;
                    state_next = SEND;
                end else if (readAll) begin
                    snap_next  = in_words;
                    cur_next   = 2'd0;
                    end_next   = SCAN_END;
                    data_next  = in0;
                    addr_next  = 2'd0;
                    valid_next = 1'b1;
                    last_next  = (SCAN_END == 2'd0);
                    busy_next  = 1'b1;
                    state_next = SEND;
                end
            end

            SEND: begin
                busy_next = 1'b1;
                if (outValid && outReady) begin
                    if (outLast) begin
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        cur_next  = cur_inc;
                        data_next = snap[cur_inc];
                        addr_next = cur_inc;
                        last_next = (cur_inc == end_addr);
                    end
                end
            end

            DONE: begin
                busy_next  = 1'b0;
                valid_next = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
